// File: rtl/aes_seq_ctrl.sv
// AES job sequencer: steps key loads and multi-block data jobs through the bus
// interface, key expander and cipher core, prefetching the next block during ENC.
module aes_seq_ctrl #(
    parameter int unsigned WORDS_PER_BLK = 4,
    parameter int unsigned BLK_W         = 8,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start_i,
    input  logic             data_type_i,
    input  logic             enc_dec_i,
    input  logic [1:0]       key_size_i,
    input  logic [BLK_W-1:0] num_blk_i,
    input  logic             data_received_i,
    input  logic             chg_key_done_i,
    input  logic             enc_done_i,
    input  logic             abort_i,
    input  logic             clr_err_i,
    output logic             opt_mode_o,
    output logic [1:0]       key_len_o,
    output logic             load_key_o,
    output logic             aes_load_o,
    output logic             aes_enable_o,
    output logic             ahb_mode_o,
    output logic             ahb_shift_en_o,
    output logic             done_chg_key_o,
    output logic             job_done_o,
    output logic             busy_o,
    output logic             error_o,
    output logic [BLK_W-1:0] blk_left_o
);

    localparam int unsigned CntW  = 5;
    localparam int unsigned WaitW = ($clog2(TIMEOUT + 1) > CntW) ? $clog2(TIMEOUT + 1) : CntW;

    typedef enum logic [2:0] {
        StIdle, StKeyFetch, StChgKey, StFetch, StLoad, StEnc, StWrite, StError
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    word_cnt_q, word_cnt_d;
    logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
    logic               pf_q, pf_d;
    logic [BLK_W-1:0]   blk_left_q, blk_left_d;
    logic               opt_mode_q, opt_mode_d;
    logic [1:0]         key_len_q, key_len_d;

    logic               accept;
    logic               blk_last;
    logic               word_last;
    logic               wait_expired;
    logic               write_last;
    logic [CntW-1:0]    key_last;

    always_comb begin
        case (key_len_q)
            2'b01:   key_last = CntW'(5);
            2'b10:   key_last = CntW'(7);
            default: key_last = CntW'(3);
        endcase
    end

    assign blk_last     = (blk_left_q == BLK_W'(1));
    assign word_last    = (word_cnt_q == CntW'(WORDS_PER_BLK - 1));
    assign wait_expired = (wait_cnt_q == WaitW'(TIMEOUT - 1));
    assign write_last   = (wait_cnt_q == WaitW'(WORDS_PER_BLK - 1));

    assign load_key_o     = (state_q == StChgKey);
    assign aes_load_o     = (state_q == StLoad);
    assign aes_enable_o   = (state_q == StEnc);
    assign ahb_mode_o     = (state_q == StWrite);
    // Prefetch only while another block still follows the one being ciphered.
    assign ahb_shift_en_o = (state_q == StKeyFetch) || (state_q == StFetch) ||
                            (state_q == StWrite) ||
                            ((state_q == StEnc) && (blk_left_q > BLK_W'(1)) && !pf_q);
    assign accept         = data_received_i && ahb_shift_en_o && !ahb_mode_o;
    assign done_chg_key_o = (state_q == StChgKey) && chg_key_done_i && !abort_i;
    assign job_done_o     = (state_q == StWrite) && write_last && blk_last && !abort_i;
    assign busy_o         = (state_q != StIdle) && (state_q != StError);
    assign error_o        = (state_q == StError);
    assign opt_mode_o     = opt_mode_q;
    assign key_len_o      = key_len_q;
    assign blk_left_o     = blk_left_q;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        wait_cnt_d = wait_cnt_q;
        pf_d       = pf_q;
        blk_left_d = blk_left_q;
        opt_mode_d = opt_mode_q;
        key_len_d  = key_len_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    word_cnt_d = '0;
                    pf_d       = 1'b0;
                    if (data_type_i && key_size_i != 2'b11) begin
                        state_d    = StKeyFetch;
                        key_len_d  = key_size_i;
                        opt_mode_d = enc_dec_i;
                    end else if (!data_type_i && num_blk_i != '0) begin
                        state_d    = StFetch;
                        blk_left_d = num_blk_i;
                        opt_mode_d = enc_dec_i;
                    end else begin
                        state_d = StError;
                    end
                end
            end
            StKeyFetch: begin
                if (accept) begin
                    if (word_cnt_q == key_last) begin
                        state_d    = StChgKey;
                        word_cnt_d = '0;
                        wait_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + CntW'(1);
                    end
                end
            end
            StChgKey: begin
                if (chg_key_done_i) begin
                    state_d = StIdle;
                end else if (wait_expired) begin
                    state_d = StError;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StFetch: begin
                if (accept) begin
                    if (word_last) begin
                        state_d = StLoad;
                    end else begin
                        word_cnt_d = word_cnt_q + CntW'(1);
                    end
                end
            end
            StLoad: begin
                state_d    = StEnc;
                word_cnt_d = '0;
                pf_d       = 1'b0;
                wait_cnt_d = '0;
            end
            StEnc: begin
                if (accept) begin
                    if (word_last) begin
                        pf_d       = 1'b1;
                        word_cnt_d = '0;
                    end else begin
                        word_cnt_d = word_cnt_q + CntW'(1);
                    end
                end
                if (enc_done_i) begin
                    state_d    = StWrite;
                    wait_cnt_d = '0;
                end else if (wait_expired) begin
                    state_d = StError;
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StWrite: begin
                // wait_cnt doubles as the write-beat counter; word_cnt holds partial prefetch.
                if (write_last) begin
                    blk_left_d = blk_left_q - BLK_W'(1);
                    if (blk_last) begin
                        state_d = StIdle;
                    end else if (pf_q) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StFetch;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + WaitW'(1);
                end
            end
            StError: begin
                if (clr_err_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (abort_i && state_q != StIdle) begin
            state_d    = StIdle;
            word_cnt_d = '0;
            wait_cnt_d = '0;
            pf_d       = 1'b0;
            blk_left_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            word_cnt_q <= '0;
            wait_cnt_q <= '0;
            pf_q       <= 1'b0;
            blk_left_q <= '0;
            opt_mode_q <= 1'b0;
            key_len_q  <= 2'b00;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            pf_q       <= pf_d;
            blk_left_q <= blk_left_d;
            opt_mode_q <= opt_mode_d;
            key_len_q  <= key_len_d;
        end
    end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Bench for aes_seq_ctrl: directed job scenarios plus random traffic, all checked
// every cycle against a countdown-style behavioural model.
module tb_aes_seq_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned BW = 8;
    localparam int unsigned TO = 8;

    localparam int P_IDLE = 0, P_KF = 1, P_CHG = 2, P_FETCH = 3;
    localparam int P_LOAD = 4, P_ENC = 5, P_WRITE = 6, P_ERR = 7;

    logic          clk;
    logic          n_rst;
    logic          start, data_type, enc_dec;
    logic [1:0]    key_size;
    logic [BW-1:0] num_blk;
    logic          data_received, chg_key_done, enc_done, abort, clr_err;
    logic          opt_mode;
    logic [1:0]    key_len;
    logic          load_key, aes_load, aes_enable, ahb_mode, ahb_shift_en;
    logic          done_chg_key, job_done, busy, error;
    logic [BW-1:0] blk_left;

    aes_seq_ctrl #(
        .WORDS_PER_BLK(W),
        .BLK_W        (BW),
        .TIMEOUT      (TO)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .start_i        (start),
        .data_type_i    (data_type),
        .enc_dec_i      (enc_dec),
        .key_size_i     (key_size),
        .num_blk_i      (num_blk),
        .data_received_i(data_received),
        .chg_key_done_i (chg_key_done),
        .enc_done_i     (enc_done),
        .abort_i        (abort),
        .clr_err_i      (clr_err),
        .opt_mode_o     (opt_mode),
        .key_len_o      (key_len),
        .load_key_o     (load_key),
        .aes_load_o     (aes_load),
        .aes_enable_o   (aes_enable),
        .ahb_mode_o     (ahb_mode),
        .ahb_shift_en_o (ahb_shift_en),
        .done_chg_key_o (done_chg_key),
        .job_done_o     (job_done),
        .busy_o         (busy),
        .error_o        (error),
        .blk_left_o     (blk_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: phase, words still needed, words prefetched, write beats left, wait cycles.
    int       m_ph, m_need, m_pf, m_beats, m_wait, m_blk;
    logic     m_opt;
    logic [1:0] m_klen;

    int tests, failed;
    int n_load_key, n_aes_load, n_enc, n_write, n_fetch, n_done_chg, n_job_done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] dut_outs();
        return {opt_mode, key_len, load_key, aes_load, aes_enable, ahb_mode, ahb_shift_en,
                done_chg_key, job_done, busy, error, blk_left};
    endfunction

    function automatic logic model_shift();
        return (m_ph == P_KF) || (m_ph == P_FETCH) || (m_ph == P_WRITE) ||
               (m_ph == P_ENC && m_blk > 1 && m_pf < int'(W));
    endfunction

    function automatic logic [19:0] model_outs();
        logic       dck, jd, bsy;
        logic [7:0] bl;
        dck = (m_ph == P_CHG) && chg_key_done && !abort;
        jd  = (m_ph == P_WRITE) && (m_beats == 1) && (m_blk == 1) && !abort;
        bsy = (m_ph != P_IDLE) && (m_ph != P_ERR);
        bl  = m_blk[7:0];
        return {m_opt, m_klen, m_ph == P_CHG, m_ph == P_LOAD, m_ph == P_ENC, m_ph == P_WRITE,
                model_shift(), dck, jd, bsy, m_ph == P_ERR, bl};
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_need = 0; m_pf = 0; m_beats = 0; m_wait = 0; m_blk = 0;
        m_opt = 1'b0; m_klen = 2'b00;
    endtask

    task automatic model_step();
        logic acc;
        acc = data_received && model_shift() && (m_ph != P_WRITE);
        if (abort && m_ph != P_IDLE) begin
            m_ph = P_IDLE; m_blk = 0; m_need = 0; m_pf = 0; m_wait = 0;
            return;
        end
        case (m_ph)
            P_IDLE: if (start) begin
                if (data_type && key_size != 2'b11) begin
                    m_ph = P_KF; m_need = 4 + 2 * int'(key_size);
                    m_klen = key_size; m_opt = enc_dec;
                end else if (!data_type && num_blk != 0) begin
                    m_ph = P_FETCH; m_need = W; m_blk = int'(num_blk); m_opt = enc_dec;
                    m_pf = 0;
                end else begin
                    m_ph = P_ERR;
                end
            end
            P_KF: if (acc) begin
                m_need--;
                if (m_need == 0) begin m_ph = P_CHG; m_wait = 0; end
            end
            P_CHG: begin
                if (chg_key_done) m_ph = P_IDLE;
                else begin
                    m_wait++;
                    if (m_wait == int'(TO)) m_ph = P_ERR;
                end
            end
            P_FETCH: if (acc) begin
                m_need--;
                if (m_need == 0) m_ph = P_LOAD;
            end
            P_LOAD: begin m_ph = P_ENC; m_pf = 0; m_wait = 0; end
            P_ENC: begin
                if (acc) m_pf++;
                if (enc_done) begin m_ph = P_WRITE; m_beats = W; end
                else begin
                    m_wait++;
                    if (m_wait == int'(TO)) m_ph = P_ERR;
                end
            end
            P_WRITE: begin
                m_beats--;
                if (m_beats == 0) begin
                    m_blk--;
                    if (m_blk == 0) m_ph = P_IDLE;
                    else if (m_pf == int'(W)) m_ph = P_LOAD;
                    else begin m_ph = P_FETCH; m_need = W - m_pf; end
                end
            end
            P_ERR: if (clr_err) m_ph = P_IDLE;
            default: m_ph = P_IDLE;
        endcase
    endtask

    // One clock: compare at the falling edge, then return just after the rising edge.
    task automatic tick();
        @(negedge clk);
        if (!n_rst) begin
            model_reset();
            chk("reset_outputs", 32'(dut_outs()), 32'h0);
        end else begin
            chk("cycle_outputs", 32'(dut_outs()), 32'(model_outs()));
            if (load_key) n_load_key++;
            if (aes_load) n_aes_load++;
            if (aes_enable) n_enc++;
            if (ahb_mode) n_write++;
            if (ahb_shift_en && !ahb_mode && !aes_enable) n_fetch++;
            if (done_chg_key) n_done_chg++;
            if (job_done) n_job_done++;
            model_step();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; data_type = 0; enc_dec = 0; key_size = 0; num_blk = 0;
        data_received = 0; chg_key_done = 0; enc_done = 0; abort = 0; clr_err = 0;
    endtask

    task automatic start_data(input int nb, input logic ed);
        start = 1; data_type = 0; num_blk = BW'(nb); enc_dec = ed;
        tick();
        start = 0;
    endtask

    task automatic feed(input int n);
        data_received = 1;
        repeat (n) tick();
        data_received = 0;
    endtask

    int b_lk, b_al, b_en, b_wr, b_fe, b_dc, b_jd;
    task automatic snap();
        b_lk = n_load_key; b_al = n_aes_load; b_en = n_enc; b_wr = n_write;
        b_fe = n_fetch; b_dc = n_done_chg; b_jd = n_job_done;
    endtask

    initial begin
        tests = 0; failed = 0;
        n_load_key = 0; n_aes_load = 0; n_enc = 0; n_write = 0; n_fetch = 0;
        n_done_chg = 0; n_job_done = 0;
        model_reset();
        idle_inputs();
        n_rst = 0;
        @(posedge clk); #1;
        tick(); tick();
        #1 n_rst = 1;
        tick();

        // Key job, 256-bit
        snap();
        start = 1; data_type = 1; key_size = 2'b10;
        tick();
        start = 0; data_type = 0; key_size = 0;
        feed(8);
        chk("key_in_chg", 32'(load_key), 32'h1);
        tick(); tick();
        chk("key_no_done_yet", 32'(n_done_chg - b_dc), 32'd0);
        chg_key_done = 1;
        tick();
        chg_key_done = 0;
        tick();
        chk("key_load_key_cycles", 32'(n_load_key - b_lk), 32'd3);
        chk("key_done_pulses", 32'(n_done_chg - b_dc), 32'd1);
        chk("key_len", 32'(key_len), 32'h2);
        chk("key_idle", 32'(busy), 32'h0);

        // Three-block decrypt job with full prefetch each ENC
        snap();
        start_data(3, 1'b1);
        chk("data_opt_mode", 32'(opt_mode), 32'h1);
        chk("data_blk_left", 32'(blk_left), 32'd3);
        feed(W);
        tick();
        for (int b = 0; b < 3; b++) begin
            if (b < 2) feed(W);
            enc_done = 1;
            tick();
            enc_done = 0;
            repeat (W) tick();
            if (b < 2) tick();
        end
        chk("data_write_cycles", 32'(n_write - b_wr), 32'd12);
        chk("data_fetch_cycles", 32'(n_fetch - b_fe), 32'd4);
        chk("data_aes_loads", 32'(n_aes_load - b_al), 32'd3);
        chk("data_job_done", 32'(n_job_done - b_jd), 32'd1);
        chk("data_blk_left_end", 32'(blk_left), 32'd0);

        // Slow bus: partial prefetch forces a short FETCH
        snap();
        start_data(2, 1'b0);
        feed(W);
        tick();
        feed(2);
        enc_done = 1;
        tick();
        enc_done = 0;
        repeat (W) tick();
        chk("slow_in_fetch", 32'({ahb_shift_en, ahb_mode, aes_enable}), 32'h4);
        feed(2);
        chk("slow_load", 32'(aes_load), 32'h1);
        tick();
        enc_done = 1;
        tick();
        enc_done = 0;
        repeat (W) tick();
        chk("slow_fetch_cycles", 32'(n_fetch - b_fe), 32'd6);
        chk("slow_job_done", 32'(n_job_done - b_jd), 32'd1);

        // ENC timeout
        snap();
        start_data(1, 1'b0);
        feed(W);
        tick();
        repeat (TO) tick();
        chk("to_error", 32'(error), 32'h1);
        chk("to_enc_cycles", 32'(n_enc - b_en), 32'(TO));
        start = 1; data_type = 0; num_blk = 1;
        repeat (3) tick();
        start = 0;
        chk("to_error_held", 32'(error), 32'h1);
        clr_err = 1;
        tick();
        clr_err = 0;
        chk("to_cleared", 32'({error, busy}), 32'h0);

        // Illegal requests
        start = 1; data_type = 1; key_size = 2'b11;
        tick();
        start = 0; data_type = 0; key_size = 0;
        chk("illegal_key", 32'(error), 32'h1);
        clr_err = 1; tick(); clr_err = 0;
        start_data(0, 1'b0);
        chk("illegal_blk", 32'(error), 32'h1);
        clr_err = 1; tick(); clr_err = 0;

        // Abort during second WRITE cycle
        snap();
        start_data(2, 1'b0);
        feed(W);
        tick();
        enc_done = 1; tick(); enc_done = 0;
        tick();
        abort = 1; tick(); abort = 0;
        chk("abort_state", 32'({busy, ahb_shift_en, ahb_mode}), 32'h0);
        chk("abort_blk_left", 32'(blk_left), 32'd0);
        tick();
        chk("abort_no_done", 32'(n_job_done - b_jd), 32'd0);

        // Asynchronous reset mid-fetch
        snap();
        start_data(2, 1'b1);
        feed(2);
        #1 n_rst = 0;
        tick(); tick();
        #1 n_rst = 1;
        repeat (3) tick();
        chk("rst_no_done", 32'(n_job_done - b_jd), 32'd0);
        chk("rst_idle", 32'({busy, opt_mode, blk_left}), 32'h0);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            start         = ($urandom % 4) == 0;
            data_type     = 1'($urandom % 2);
            enc_dec       = 1'($urandom % 2);
            key_size      = 2'($urandom % 4);
            num_blk       = BW'($urandom % 5);
            data_received = ($urandom % 3) != 0;
            chg_key_done  = ($urandom % 4) == 0;
            enc_done      = ($urandom % 5) == 0;
            abort         = ($urandom % 80) == 0;
            clr_err       = ($urandom % 3) == 0;
            tick();
        end
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/aes_seq_ctrl.md
AES_SEQ_CTRL -- requirements
Module: aes_seq_ctrl

Interface
REQ-001 Parameter WORDS_PER_BLK, default 4, 32-bit words per data block; legal range 2..16.
REQ-002 Parameter BLK_W, default 8, width of block-count input.
REQ-003 Parameter TIMEOUT, default 255, maximum wait cycles in CHG_KEY or ENC before error.
REQ-004 Reset n_rst, asynchronous, active-low; clock clk.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 n_rst  in  1  asynchronous active-low reset.
REQ-007 start  in  1  one-cycle request from bus interface; sampled only in IDLE.
REQ-008 data_type  in  1  1 = key load, 0 = data job; sampled with start.
REQ-009 enc_dec  in  1  0 = encrypt, 1 = decrypt; sampled with start.
REQ-010 key_size  in  2  00 = 128-bit (4 words), 01 = 192-bit (6), 10 = 256-bit (8), 11 = illegal; sampled with start.
REQ-011 num_blk  in  BLK_W  blocks in data job; sampled with start; 0 = illegal.
REQ-012 data_received  in  1  bus word-valid strobe; counted only when ahb_shift_en = 1 and ahb_mode = 0.
REQ-013 chg_key_done  in  1  key expansion complete.
REQ-014 enc_done  in  1  cipher core finished current block.
REQ-015 abort  in  1  synchronous abort of any job.
REQ-016 clr_err  in  1  clears ERROR.
REQ-017 opt_mode  out  1  registered enc_dec of current job.
REQ-018 key_len  out  2  registered key_size of last key job.
REQ-019 load_key, aes_load, aes_enable, ahb_mode, ahb_shift_en  out  1 each  controls to key gen, cipher core and bus interface.
REQ-020 done_chg_key, job_done  out  1 each  one-cycle completion pulses.
REQ-021 busy, error  out  1 each  busy = state not IDLE/ERROR; error = state is ERROR.
REQ-022 blk_left  out  BLK_W  blocks not yet written.

Function
REQ-023 States: IDLE, KEY_FETCH, CHG_KEY, FETCH, LOAD, ENC, WRITE, ERROR; all outputs combinational from state and counters except the registered opt_mode, key_len, blk_left.
REQ-024 IDLE + start: data_type = 1 and key_size != 11 -> KEY_FETCH; data_type = 0 and num_blk != 0 -> FETCH; otherwise -> ERROR.
REQ-025 KEY_FETCH: ahb_shift_en = 1, ahb_mode = 0; word counter increments per data_received; on word (4/6/8 by key_size) - 1 accepted -> CHG_KEY.
REQ-026 CHG_KEY: load_key = 1 continuously; chg_key_done -> IDLE with done_chg_key = 1 for that exiting cycle only.
REQ-027 FETCH: ahb_shift_en = 1, ahb_mode = 0; after WORDS_PER_BLK words accepted -> LOAD.
REQ-028 LOAD: aes_load = 1 for exactly one cycle -> ENC; word counter and prefetch flag cleared.
REQ-029 ENC: aes_enable = 1; if blk_left > 1 and prefetch incomplete, ahb_shift_en = 1 and words are counted into the prefetch; prefetch flag sets when WORDS_PER_BLK words are accepted.
REQ-030 ENC + enc_done -> WRITE; a word accepted in the same cycle as enc_done is counted.
REQ-031 WRITE: ahb_mode = 1, ahb_shift_en = 1 for exactly WORDS_PER_BLK cycles; blk_left decrements on last cycle.
REQ-032 WRITE exit: blk_left was 1 -> IDLE with job_done pulse; else prefetch flag set -> LOAD; else -> FETCH, keeping any partial prefetch count.
REQ-033 Wait counter counts cycles in CHG_KEY and ENC, cleared on entry; reaching TIMEOUT without the done input -> ERROR.
REQ-034 ERROR: all control outputs 0, error = 1; clr_err -> IDLE; start ignored.
REQ-035 abort in any state except IDLE -> IDLE next cycle, no done pulses, counters cleared; abort has priority over all other transitions.
REQ-036 data_received when ahb_shift_en = 0 or ahb_mode = 1 is ignored.

Reset
REQ-037 n_rst low: state IDLE, all counters 0, opt_mode 0, key_len 00, blk_left 0, all pulse and control outputs 0.
REQ-038 Reset asserted mid-job takes effect immediately; no done pulse follows reset release.

Verification
REQ-039 Key job: start, data_type = 1, key_size = 10, 8 data_received strobes, chg_key_done 3 cycles later -> load_key high 3 cycles, one done_chg_key pulse, key_len = 10.
REQ-040 Data job: num_blk = 3, enc_dec = 1, words fed during every ENC -> blocks 2 and 3 go WRITE -> LOAD with no FETCH, 3 WRITE bursts of 4 cycles, one job_done, opt_mode = 1.
REQ-041 Slow bus: num_blk = 2, only 2 words supplied during ENC -> after WRITE enters FETCH, needs 2 more words, then LOAD.
REQ-042 Timeout: TIMEOUT = 8, enc_done never asserted -> ERROR after 8 ENC cycles, error = 1 until clr_err.
REQ-043 Illegal: key_size = 11 with data_type = 1, and num_blk = 0 with data_type = 0 -> ERROR directly from IDLE.
REQ-044 Abort during WRITE cycle 2 -> IDLE next cycle, ahb_shift_en 0, no job_done, blk_left 0.
